// File: rtl/simon_pkg.sv
// Shared definitions for the parametrised SIMON encryption core: z sequences,
// FSM state type and parameter legality / default helpers.
package simon_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int unsigned ZLen = 62;

    // Published z sequences as written, leftmost symbol in bit 61.
    localparam logic [61:0] ZPub [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    function automatic logic [61:0] rev62(input logic [61:0] v);
        logic [61:0] r;
        for (int unsigned i = 0; i < 62; i++) begin
            r[i] = v[61-i];
        end
        return r;
    endfunction

    // Z[j][i] is symbol i of sequence j.
    localparam logic [61:0] Z [5] = '{
        rev62(ZPub[0]), rev62(ZPub[1]), rev62(ZPub[2]), rev62(ZPub[3]), rev62(ZPub[4])
    };

    // Standard round count per (N, M); 0 marks a non-standard pair.
    function automatic int unsigned std_rounds(input int unsigned n, input int unsigned m);
        int unsigned t;
        t = 0;
        case ({n[7:0], m[7:0]})
            {8'd16, 8'd4}: t = 32;
            {8'd24, 8'd3}: t = 36;
            {8'd24, 8'd4}: t = 36;
            {8'd32, 8'd3}: t = 42;
            {8'd32, 8'd4}: t = 44;
            {8'd48, 8'd2}: t = 52;
            {8'd48, 8'd3}: t = 54;
            {8'd64, 8'd2}: t = 68;
            {8'd64, 8'd3}: t = 69;
            {8'd64, 8'd4}: t = 72;
            default:       t = 0;
        endcase
        if (n > 255 || m > 255) t = 0;
        return t;
    endfunction

    function automatic int unsigned std_zidx(input int unsigned n, input int unsigned m);
        int unsigned z;
        z = 0;
        case ({n[7:0], m[7:0]})
            {8'd24, 8'd4}: z = 1;
            {8'd32, 8'd3}: z = 2;
            {8'd32, 8'd4}: z = 3;
            {8'd48, 8'd2}: z = 2;
            {8'd48, 8'd3}: z = 3;
            {8'd64, 8'd2}: z = 2;
            {8'd64, 8'd3}: z = 3;
            {8'd64, 8'd4}: z = 4;
            default:       z = 0;
        endcase
        return z;
    endfunction

    function automatic bit params_legal(input int unsigned n, input int unsigned m,
                                        input int unsigned t, input int unsigned zidx);
        return (std_rounds(n, m) != 0) && (t >= m) && (zidx <= 4);
    endfunction

endpackage

// File: rtl/simon_round_fn.sv
// One SIMON Feistel round: x' = y ^ f(x) ^ k, y' = x.
module simon_round_fn #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic [N-1:0] i_k,
    output logic [N-1:0] o_x,
    output logic [N-1:0] o_y
);

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    always_comb begin
        o_x = i_y ^ (rotl(i_x, 1) & rotl(i_x, 8)) ^ rotl(i_x, 2) ^ i_k;
        o_y = i_x;
    end

endmodule

// File: rtl/simon_core_param.sv
// Iterative SIMON 2N/MN encryption core: one round per clock, on-the-fly key
// schedule held in an M-word shift register, valid/ready on both sides.
module simon_core_param
    import simon_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned M    = 4,
    parameter int unsigned T    = std_rounds(N, M),
    parameter int unsigned ZIDX = std_zidx(N, M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_pt,
    input  logic [M*N-1:0]   in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_ct,
    output logic             busy
);

    if (!params_legal(N, M, T, ZIDX)) begin : g_bad_params
        $error("simon_core_param: illegal combination of N, M, T, ZIDX");
    end

    localparam int unsigned CntW    = $clog2(T + 1);
    localparam logic [61:0] ZSeq    = Z[ZIDX];

    state_e           r_state;
    state_e           w_state_next;
    logic [N-1:0]     r_x;
    logic [N-1:0]     r_y;
    logic [N-1:0]     r_kr [M];
    logic [CntW-1:0]  r_round;
    logic [2*N-1:0]   r_ct;

    logic [N-1:0]     w_x_next;
    logic [N-1:0]     w_y_next;
    logic [N-1:0]     w_tmp;
    logic [N-1:0]     w_key_new;
    logic [5:0]       w_zi;
    logic             w_z;
    logic             w_accept;
    logic             w_last;

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int unsigned s);
        return (v >> s) | (v << (N - s));
    endfunction

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_round == CntW'(T - 1));
    assign w_zi     = 6'(32'(r_round) % ZLen);
    assign w_z      = ZSeq[w_zi];

    // Next key word k[i+M] from the current window k[i..i+M-1].
    always_comb begin
        w_tmp = rotr(r_kr[M-1], 3);
        if (M == 4) w_tmp = w_tmp ^ r_kr[1];
        w_tmp     = w_tmp ^ rotr(w_tmp, 1);
        w_key_new = ~r_kr[0] ^ w_tmp ^ {{(N-1){1'b0}}, w_z} ^ N'(3);
    end

    simon_round_fn #(
        .N(N)
    ) u_round (
        .i_x (r_x),
        .i_y (r_y),
        .i_k (r_kr[0]),
        .o_x (w_x_next),
        .o_y (w_y_next)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_round <= '0;
            r_ct    <= '0;
            for (int unsigned j = 0; j < M; j++) begin
                r_kr[j] <= '0;
            end
        end else if (w_accept) begin
            r_x     <= in_pt[2*N-1:N];
            r_y     <= in_pt[N-1:0];
            r_round <= '0;
            for (int unsigned j = 0; j < M; j++) begin
                r_kr[j] <= in_key[j*N +: N];
            end
        end else if (r_state == RUN) begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_round <= r_round + CntW'(1);
            for (int unsigned j = 0; j < M - 1; j++) begin
                r_kr[j] <= r_kr[j+1];
            end
            r_kr[M-1] <= w_key_new;
            if (w_last) r_ct <= {w_x_next, w_y_next};
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_ct    = r_ct;

endmodule

// File: tb/tb_simon_core_param.sv
// Self-checking bench for simon_core_param: known-answer and random vectors on
// three configurations, backpressure, reset abort and back-to-back streaming.
module tb_simon_core_param;

    localparam int CfgN [3] = '{16, 32, 64};
    localparam int CfgM [3] = '{4, 4, 2};
    localparam int CfgT [3] = '{32, 44, 68};
    localparam int CfgZ [3] = '{0, 3, 2};

    localparam logic [61:0] ZTab [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   iv, ore, ir, ov, bz;
    logic [127:0] pt_w;
    logic [255:0] key_w;
    logic [31:0]  ct0;
    logic [63:0]  ct1;
    logic [127:0] ct2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    simon_core_param u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_pt(pt_w[31:0]),
        .in_key(key_w[63:0]), .out_valid(ov[0]), .out_ready(ore[0]), .out_ct(ct0),
        .busy(bz[0])
    );

    simon_core_param #(.N(32), .M(4), .T(44), .ZIDX(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_pt(pt_w[63:0]),
        .in_key(key_w[127:0]), .out_valid(ov[1]), .out_ready(ore[1]), .out_ct(ct1),
        .busy(bz[1])
    );

    simon_core_param #(.N(64), .M(2), .T(68), .ZIDX(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_pt(pt_w[127:0]),
        .in_key(key_w[127:0]), .out_valid(ov[2]), .out_ready(ore[2]), .out_ct(ct2),
        .busy(bz[2])
    );

    // Reference: expand the full key schedule into an array, then run T rounds.
    function automatic logic [63:0] rotl_m(input logic [63:0] v, input int s, input int n,
                                           input logic [63:0] mask);
        return ((v << s) | (v >> (n - s))) & mask;
    endfunction

    function automatic logic [127:0] simon_ref(input int n, input int m, input int t,
                                               input int zi, input logic [255:0] key,
                                               input logic [127:0] pt);
        logic [63:0] mask, x, y, tmp;
        logic [63:0] k [0:71];
        logic [61:0] zs;
        zs   = ZTab[zi];
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = rotl_m(k[i-1], n - 3, n, mask);
            if (m == 4) tmp = tmp ^ k[i-3];
            tmp  = tmp ^ rotl_m(tmp, n - 1, n, mask);
            k[i] = (~k[i-m] & mask) ^ tmp ^ 64'(zs[61 - ((i - m) % 62)]) ^ 64'd3;
        end
        x = 64'(pt >> n) & mask;
        y = pt[63:0] & mask;
        for (int i = 0; i < t; i++) begin
            tmp = x;
            x = y ^ (rotl_m(x, 1, n, mask) & rotl_m(x, 8, n, mask)) ^ rotl_m(x, 2, n, mask)
                ^ k[i];
            y = tmp;
        end
        return ({64'd0, x} << n) | {64'd0, y};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] get_ct(input int d);
        case (d)
            0:       return {96'd0, ct0};
            1:       return {64'd0, ct1};
            default: return ct2;
        endcase
    endfunction

    // Accept one block on DUT d, check latency, result and return to idle.
    task automatic run_block(input int d, input logic [127:0] pt, input logic [255:0] key,
                             input logic [127:0] exp, input string name);
        int cyc;
        @(negedge clk);
        check({name, " in_ready"}, 128'(ir[d]), 128'd1);
        pt_w  = pt;
        key_w = key;
        ore[d] = 1'b1;
        iv[d]  = 1'b1;
        @(negedge clk);
        iv[d] = 1'b0;
        cyc   = 0;
        while (!ov[d] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 128'(cyc), 128'(CfgT[d]));
        check({name, " ct"}, get_ct(d), exp);
        @(negedge clk);
        check({name, " back to idle"}, 128'({ov[d], ir[d]}), 128'b01);
    endtask

    typedef struct {
        int           d;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [127:0] rpt;
        logic [255:0] rkey;
        logic [127:0] exp_q[$];
        int           cyc, last_acc, accepted, got, seen_ov;

        rst = 1'b1; iv = '0; ore = '0; pt_w = '0; key_w = '0;

        vecs.push_back('{0, 128'h65656877, 256'h1918111009080100, 128'hc69be9bb, "kat32_64"});
        vecs.push_back('{1, 128'h656b696c20646e75, 256'h1b1a191813121110_0b0a090803020100,
                         128'h44c8fc20b9dfa07a, "kat64_128"});
        vecs.push_back('{2, 128'h6373656420737265_6c6c657661727420,
                         256'h0f0e0d0c0b0a0908_0706050403020100,
                         128'h49681b1e1e54fe3f_65aa832af84e0bbc, "kat128_128"});
        for (int r = 0; r < 6; r++) begin
            int d;
            d    = r % 3;
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom};
            vecs.push_back('{d, rpt, rkey,
                             simon_ref(CfgN[d], CfgM[d], CfgT[d], CfgZ[d], rkey, rpt),
                             $sformatf("rand%0d_dut%0d", r, d)});
        end

        repeat (2) @(negedge clk);
        check("reset in_ready", 128'(ir), 128'b111);
        check("reset out_valid/busy", 128'({ov, bz}), 128'd0);
        check("reset out_ct", get_ct(0) | get_ct(2), 128'd0);
        rst = 1'b0;

        foreach (vecs[v]) run_block(vecs[v].d, vecs[v].pt, vecs[v].key, vecs[v].exp,
                                    vecs[v].name);

        // Backpressure: result held, in_valid pulses ignored.
        @(negedge clk);
        pt_w = 128'h65656877; key_w = 256'h1918111009080100;
        ore[0] = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        cyc = 0;
        while (!ov[0] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", 128'(cyc), 128'd32);
        for (int i = 0; i < 10; i++) begin
            iv[0] = i[0];
            pt_w  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp hold ct", get_ct(0), 128'hc69be9bb);
            check("bp valid/ready", 128'({ov[0], ir[0], bz[0]}), 128'b101);
        end
        iv[0] = 1'b0; ore[0] = 1'b1;
        @(negedge clk);
        check("bp release", 128'({ov[0], ir[0]}), 128'b01);
        check("bp ct retained", get_ct(0), 128'hc69be9bb);

        // Reset in the middle of a run discards the block.
        @(negedge clk);
        pt_w = 128'h65656877; key_w = 256'h1918111009080100;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy before reset", 128'(bz[0]), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort reset state", 128'({ov[0], ir[0], bz[0]}), 128'b010);
        check("abort ct cleared", get_ct(0), 128'd0);
        seen_ov = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ov[0]) seen_ov++;
        end
        check("abort no out_valid", 128'(seen_ov), 128'd0);
        run_block(0, 128'h65656877, 256'h1918111009080100, 128'hc69be9bb, "after abort");

        // Back-to-back with in_valid held high.
        ore[0] = 1'b1; iv[0] = 1'b1;
        cyc = 0; last_acc = -1; accepted = 0; got = 0;
        while (got < 4 && cyc < 1000) begin
            if (ov[0]) begin
                if (exp_q.size() > 0) check("b2b ct", get_ct(0), exp_q.pop_front());
                else check("b2b unexpected result", 128'(ov[0]), 128'd0);
                got++;
            end
            if (ir[0]) begin
                if (accepted < 4) begin
                    rpt  = 128'({$urandom});
                    rkey = 256'({$urandom, $urandom});
                    pt_w = rpt; key_w = rkey;
                    exp_q.push_back(simon_ref(16, 4, 32, 0, rkey, rpt));
                    if (last_acc >= 0) check("b2b spacing", 128'(cyc - last_acc), 128'd34);
                    last_acc = cyc;
                    accepted++;
                end else begin
                    iv[0] = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        iv[0] = 1'b0;
        check("b2b results", 128'(got), 128'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
